// File: rtl/led_pattern_pkg.sv
// Shared mode codes and sizing helpers for the LED pattern generator.
package led_pattern_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_PWM     = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd4;

    function automatic logic mode_valid(input logic [MODE_W-1:0] m);
        return m <= MODE_BREATHE;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: latched mode/duty, blink and breathe state, and the
// compare that produces the channel's next LED value.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int PWM_BITS           = 8,
    parameter int BLINK_TICKS        = 500,
    parameter int BREATHE_STEP_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_load,
    input  logic [MODE_W-1:0]   i_mode,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_next
);

    localparam int BLK_W = cnt_w(BLINK_TICKS);
    localparam int STP_W = cnt_w(BREATHE_STEP_TICKS);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [STP_W-1:0]    STP_LAST = STP_W'(BREATHE_STEP_TICKS - 1);
    localparam logic [PWM_BITS-1:0] BR_MAX   = '1;

    logic [MODE_W-1:0]   r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_phase;
    logic [STP_W-1:0]    r_step_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic                r_dir_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_OFF;
            r_duty <= '0;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_duty <= i_duty;
        end
    end

    // A load restarts the pattern with the LED lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (i_load) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (i_tick && r_mode == MODE_BLINK) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // At either end of the ramp the direction flips in place of a step,
    // so the extreme brightness is held for one extra step period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_bright   <= '0;
            r_dir_up   <= 1'b1;
        end else if (i_load) begin
            r_step_cnt <= '0;
            r_bright   <= '0;
            r_dir_up   <= 1'b1;
        end else if (i_tick && r_mode == MODE_BREATHE) begin
            if (r_step_cnt == STP_LAST) begin
                r_step_cnt <= '0;
                if (r_dir_up) begin
                    if (r_bright == BR_MAX) r_dir_up <= 1'b0;
                    else                    r_bright <= r_bright + 1'b1;
                end else begin
                    if (r_bright == '0)     r_dir_up <= 1'b1;
                    else                    r_bright <= r_bright - 1'b1;
                end
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_next = 1'b0;
        case (r_mode)
            MODE_ON:      o_next = 1'b1;
            MODE_BLINK:   o_next = r_phase;
            MODE_PWM:     o_next = (i_pwm_cnt < r_duty);
            MODE_BREATHE: o_next = (i_pwm_cnt < r_bright);
            default:      o_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared timebase and PWM counter,
// config handshake/decode, per-channel pattern units and output register.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_CH             = 4,
    parameter int PWM_BITS           = 8,
    parameter int PRESC_DIV          = 16000,
    parameter int BLINK_TICKS        = 500,
    parameter int BREATHE_STEP_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                cfg_err,
    output logic                tick,
    output logic [NUM_CH-1:0]   ch_led,
    output logic                ch_usbpu
);

    localparam int              PS_W    = cnt_w(PRESC_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC_DIV - 1);
    localparam logic [4:0]      CH_LIM  = 5'(NUM_CH);

    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_ready;
    logic                r_err;
    logic [NUM_CH-1:0]   r_led;

    logic                w_tick;
    logic                w_xfer;
    logic                w_cfg_ok;
    logic [NUM_CH-1:0]   w_load;
    logic [NUM_CH-1:0]   w_next;

    assign w_tick   = (r_presc == PS_LAST);
    assign w_xfer   = cfg_valid && r_ready;
    assign w_cfg_ok = ({1'b0, cfg_ch} < CH_LIM) && mode_valid(cfg_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    // Ready drops for the cycle after every accepted transfer, and rises
    // on the first edge out of reset since r_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= ~w_xfer;
            r_err   <= w_xfer && !w_cfg_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = w_xfer && w_cfg_ok && (cfg_ch == 4'(g));

        led_channel #(
            .PWM_BITS           (PWM_BITS),
            .BLINK_TICKS        (BLINK_TICKS),
            .BREATHE_STEP_TICKS (BREATHE_STEP_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm),
            .i_load    (w_load[g]),
            .i_mode    (cfg_mode),
            .i_duty    (cfg_duty),
            .o_next    (w_next[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_led <= '0;
        else        r_led <= w_next;
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = w_tick;
    assign ch_led    = r_led;
    assign ch_usbpu  = 1'b0;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen against a per-channel model that
// derives each LED from ticks elapsed since the channel was last loaded.
module tb_led_pattern_gen;

    localparam int NUM_CH = 4;
    localparam int PWM_BITS = 4;
    localparam int PRESC_DIV = 4;
    localparam int BLINK_TICKS = 3;
    localparam int STEP_TICKS = 2;
    localparam int MAXB = (1 << PWM_BITS) - 1;

    logic                clk;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [3:0]          cfg_ch;
    logic [2:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_err;
    logic                tick;
    logic [NUM_CH-1:0]   ch_led;
    logic                ch_usbpu;

    led_pattern_gen #(
        .NUM_CH             (NUM_CH),
        .PWM_BITS           (PWM_BITS),
        .PRESC_DIV          (PRESC_DIV),
        .BLINK_TICKS        (BLINK_TICKS),
        .BREATHE_STEP_TICKS (STEP_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .ch_led    (ch_led),
        .ch_usbpu  (ch_usbpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: cycles since reset release, per-channel mode/duty and
    // ticks seen since the last load.
    int              m_cyc = 0;
    bit              m_ready = 1'b0;
    bit              m_err = 1'b0;
    logic [NUM_CH-1:0] m_led = '0;
    int              m_mode [NUM_CH] = '{default: 0};
    int              m_duty [NUM_CH] = '{default: 0};
    int              m_nt   [NUM_CH] = '{default: 0};

    int m_pwm;
    bit m_tk, m_xfer, m_ok;
    assign m_pwm  = m_cyc % (MAXB + 1);
    assign m_tk   = (m_cyc % PRESC_DIV) == PRESC_DIV - 1;
    assign m_xfer = cfg_valid && m_ready;
    assign m_ok   = (int'(cfg_ch) < NUM_CH) && (int'(cfg_mode) < 5);

    function automatic logic model_out(input int md, input int dt, input int nt, input int pwm);
        int m, b;
        case (md)
            1: return 1'b1;
            2: return ((nt / BLINK_TICKS) % 2) == 0;
            3: return pwm < dt;
            4: begin
                // Triangle: 0..MAX, hold MAX, MAX-1..0, hold 0; period 2*(MAX+1) steps.
                m = (nt / STEP_TICKS) % (2 * (MAXB + 1));
                b = (m <= MAXB) ? m : 2 * MAXB + 1 - m;
                return pwm < b;
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_led   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] <= 0;
                m_duty[c] <= 0;
                m_nt[c]   <= 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_led[c] <= model_out(m_mode[c], m_duty[c], m_nt[c], m_pwm);
                if (m_xfer && m_ok && int'(cfg_ch) == c) begin
                    m_mode[c] <= int'(cfg_mode);
                    m_duty[c] <= int'(cfg_duty);
                    m_nt[c]   <= 0;
                end else if (m_tk) begin
                    m_nt[c] <= m_nt[c] + 1;
                end
            end
            m_err   <= m_xfer && !m_ok;
            m_ready <= !m_xfer;
            m_cyc   <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("led", 32'(ch_led), 32'(m_led));
            chk("ready", 32'(cfg_ready), 32'(m_ready));
            chk("err", 32'(cfg_err), 32'(m_err));
            chk("tick", 32'(tick), 32'((m_cyc % PRESC_DIV) == PRESC_DIV - 1));
            chk("usbpu", 32'(ch_usbpu), 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int ch, input int md, input int dt);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_mode  = 3'(md);
        cfg_duty  = PWM_BITS'(dt);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic count_high(input int idx, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ch_led[idx]) hi++;
        end
    endtask

    int hi;

    initial begin
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_duty  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1 chk_on = 1'b1;

        repeat (10) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_led", 32'(ch_led), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_rise", 32'(cfg_ready), 32'd1);
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (tick) hi++;
        end
        chk("tick_rate", 32'(hi), 32'd2);

        send(0, 1, 0);
        chk("on_lat1", 32'(ch_led[0]), 32'd0);
        @(negedge clk);
        chk("on_lat2", 32'(ch_led[0]), 32'd1);

        send(1, 2, 0);
        repeat (60) @(negedge clk);

        send(2, 3, 4);
        @(negedge clk);
        count_high(2, 16, hi);
        chk("pwm_d4", 32'(hi), 32'd4);
        send(2, 3, 0);
        @(negedge clk);
        count_high(2, 16, hi);
        chk("pwm_d0", 32'(hi), 32'd0);
        send(2, 3, 15);
        @(negedge clk);
        count_high(2, 16, hi);
        chk("pwm_d15", 32'(hi), 32'd15);

        send(3, 4, 0);
        repeat (600) @(negedge clk);

        send(5, 1, 0);
        chk("err_ch", 32'(cfg_err), 32'd1);
        @(negedge clk);
        chk("err_once", 32'(cfg_err), 32'd0);
        send(0, 6, 0);
        chk("err_mode", 32'(cfg_err), 32'd1);
        repeat (4) @(negedge clk);

        // Back-to-back: second beat is held off by the ready gap.
        while (cfg_ready !== 1'b1) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_mode = 3'd1; cfg_duty = '0;
        chk("b2b_r0", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        chk("b2b_r1", 32'(cfg_ready), 32'd0);
        cfg_ch = 4'd0; cfg_mode = 3'd0;
        @(negedge clk);
        chk("b2b_r2", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("b2b_apply", 32'(ch_led[1:0]), 32'd2);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_ch    = 4'($urandom_range(0, 5));
            cfg_mode  = 3'($urandom_range(0, 6));
            cfg_duty  = PWM_BITS'($urandom);
        end
        @(negedge clk);
        cfg_valid = 1'b0;

        send(1, 2, 0);
        send(0, 1, 0);
        repeat (5) @(negedge clk);
        chk("pre_arst", 32'(ch_led[0]), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(ch_led), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_off", 32'(ch_led), 32'd0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED pattern generator for the TinyFPGA BX, successor to the single-LED blinker top. It drives NUM_CH LED outputs, each independently configured at runtime through a valid/ready config port. Modes are OFF, ON, BLINK, fixed-duty PWM and BREATHE (triangle-ramped PWM). It also holds ch_usbpu low so USB stays detached, and sits directly under the board top, after the PLL.

Parameters:
NUM_CH, 4, number of LED channels (1..16)
PWM_BITS, 8, PWM counter / duty / brightness width
PRESC_DIV, 16000, clk cycles per timebase tick (>=2); 16 MHz gives a 1 kHz tick
BLINK_TICKS, 500, ticks per BLINK half-period (>=1)
BREATHE_STEP_TICKS, 4, ticks per BREATHE brightness step (>=1)

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready
cfg_ch  in  4  target channel index
cfg_mode  in  3  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE, 5-7 reserved
cfg_duty  in  PWM_BITS  duty for PWM mode; ignored otherwise
cfg_err  out  1  one-cycle pulse when a transfer is rejected
tick  out  1  one-cycle timebase pulse (debug)
ch_led  out  NUM_CH  registered LED outputs
ch_usbpu  out  1  USB pull-up, constant 0

Behaviour:
- Reset (async assert, sync to clk on release):
  - ch_led=0, cfg_ready=0, cfg_err=0, tick=0.
  - All channels in OFF with duty=0; all counters 0.
  - cfg_ready rises at the first clk edge after rst_n deasserts.
- Prescaler:
  - Counts 0..PRESC_DIV-1, then wraps.
  - tick=1 for exactly the cycle in which count==PRESC_DIV-1.
- PWM counter:
  - Shared, free-running PWM_BITS counter; increments every clk and wraps at 2^PWM_BITS-1 -> 0.
- Config handshake:
  - On transfer, cfg_ready=0 the next cycle and returns to 1 the cycle after. This gives at most one transfer every 2 cycles.
  - The new mode applies from the cycle after the transfer.
  - If cfg_ch>=NUM_CH or cfg_mode>=5: no channel changes and cfg_err pulses 1 the cycle after the transfer. The transfer is still consumed.
  - On a valid transfer the target channel's blink counter, blink phase, step counter and brightness are cleared. Blink phase is cleared to 1 (LED on), brightness to 0, and direction to up.
- Per-channel next-output (ch_led is registered, so it follows next-output with 1-cycle latency):
  - OFF: 0.
  - ON: 1.
  - BLINK: a tick counter runs 0..BLINK_TICKS-1. On the tick where count==BLINK_TICKS-1, the phase toggles and count goes to 0. Next-output = phase.
  - PWM: next-output = (pwm_cnt < duty). duty=0 gives constant 0; duty=2^PWM_BITS-1 gives low for 1 of every 2^PWM_BITS cycles.
  - BREATHE:
    - The step counter runs 0..BREATHE_STEP_TICKS-1. On wrap, brightness steps +1 if direction is up, otherwise -1.
    - At max brightness (all ones) while up, direction flips to down without stepping. At 0 while down, it flips to up likewise.
    - Next-output = (pwm_cnt < brightness).
- Reconfiguring a channel to its current mode still clears its state (restart).
- Channels not addressed by a transfer are unaffected, including on the same cycle.
- Reset mid-pattern: all state returns to reset values immediately (asynchronous).
- Counters saturate nowhere; everything wraps as stated. Counter widths are $clog2 of the respective parameter (minimum 1).

Decomposition:
- Package led_pattern_pkg: mode localparams (MODE_OFF..MODE_BREATHE), MODE_W=3, and a function validating a mode code.
- Sub-module led_channel, instantiated NUM_CH times via generate. It holds per-channel mode/duty registers, the blink and breathe state, and the compare logic. Inputs: clk, rst_n, tick, pwm_cnt, load, mode, duty. Output: next-output.
- The prescaler, PWM counter, handshake/decode and output register live in the top.

Test Plan:
Use PRESC_DIV=4, PWM_BITS=4, BLINK_TICKS=3, BREATHE_STEP_TICKS=2, NUM_CH=4.
1. Reset:
   - Hold rst_n=0 for 10 cycles, then release -> ch_led=0, cfg_ready=0 during reset and 1 on the 1st edge after release, ch_usbpu=0.
   - tick pulses on every 4th cycle.
2. ON / BLINK:
   - Write ch0 ON -> ch_led[0]=1 two cycles after the transfer.
   - Write ch1 BLINK -> ch_led[1] is high for 3 ticks (12 cycles), then low for 12, repeating.
3. PWM:
   - Write ch2 PWM duty=4 -> ch_led[2] is high for 4 of every 16 cycles.
   - duty=0 -> stays 0; duty=15 -> low for exactly 1 of 16 cycles.
4. BREATHE:
   - Write ch3 BREATHE -> brightness 0->15 in steps every 8 cycles, holds one step period at 15, then ramps down.
   - Measured high-count per 16-cycle window tracks brightness ±1.
5. Errors / handshake:
   - cfg_ch=5 or cfg_mode=6 -> cfg_err pulses once, all ch_led unchanged.
   - Back-to-back cfg_valid -> cfg_ready toggles 1,0,1 and both transfers are applied in order.
6. Async reset mid-BLINK:
   - Assert rst_n between clock edges -> ch_led goes to 0 without waiting for a clk edge.
   - After release, all channels are OFF.
